// File: rtl/alu_serial_pkg.sv
// Shared opcode and state encodings for the digit-serial ALU.
package alu_serial_pkg;

    localparam logic [1:0] OP_NAND = 2'b00;
    localparam logic [1:0] OP_XOR  = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_SUB  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_serial_digit.sv
// One DIGIT-wide ALU slice; ripple carry for ADD/SUB, carry forced to 0 for logic ops.
module alu_digit
    import alu_serial_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic [DIGIT-1:0] y,
    output logic             cout
);

    always_comb begin : ripple
        logic [DIGIT-1:0] b_eff;
        logic             c;
        b_eff = (op == OP_SUB) ? ~b : b;
        c     = cin;
        y     = '0;
        cout  = 1'b0;
        case (op)
            OP_NAND: y = ~(a & b);
            OP_XOR:  y = a ^ b;
            default: begin
                for (int i = 0; i < DIGIT; i++) begin
                    y[i] = a[i] ^ b_eff[i] ^ c;
                    c    = (a[i] & b_eff[i]) | (c & (a[i] ^ b_eff[i]));
                end
                cout = c;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// Digit-serial ALU: accepts one operation in IDLE, processes one DIGIT slice per
// cycle in RUN, and holds the result in DONE until the consumer takes it.
module alu_serial
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             c_out,
    output logic             zero
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("alu_serial: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic              c_out_q, c_out_d;
    logic              zero_q, zero_d;

    logic [DIGIT-1:0]  a_dig, b_dig, dig_y;
    logic              dig_cout;

    assign a_dig = a_q[int'(idx_q)*DIGIT +: DIGIT];
    assign b_dig = b_q[int'(idx_q)*DIGIT +: DIGIT];

    alu_digit #(.DIGIT(DIGIT)) u_digit (
        .a    (a_dig),
        .b    (b_dig),
        .op   (op_q),
        .cin  (carry_q),
        .y    (dig_y),
        .cout (dig_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        y_d     = y_q;
        c_out_d = c_out_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    idx_d   = '0;
                    carry_d = (op == OP_SUB);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                y_d[int'(idx_q)*DIGIT +: DIGIT] = dig_y;
                carry_d = dig_cout;
                idx_d   = idx_q + 1'b1;
                // Flags are committed only with the final digit so they always describe a whole result.
                if (idx_q == LAST_IDX) begin
                    c_out_d = dig_cout;
                    zero_d  = (y_d == '0);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_NAND;
            y_q     <= '0;
            c_out_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            y_q     <= y_d;
            c_out_q <= c_out_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign y         = y_q;
    assign c_out     = c_out_q;
    assign zero      = zero_q;

endmodule

// File: doc/alu_serial.md
ALU_SERIAL -- requirements
Module: alu_serial

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits.
REQ-002 Parameter DIGIT, default 4: bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT; NDIG = WIDTH/DIGIT.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  2  opcode: NAND=00, XOR=01, ADD=10, SUB=11.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 y  output  WIDTH  result.
REQ-013 c_out  output  1  carry flag.
REQ-014 zero  output  1  asserted when y == 0.

Function
REQ-015 FSM states: IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 IDLE with in_valid=1: latch a, b and op; clear digit index to 0; preset carry register = 1 for SUB, else 0; go to RUN.
REQ-017 RUN: each cycle processes digit [idx*DIGIT +: DIGIT], writes it into the y register, updates the carry register, increments idx; after digit NDIG-1 go to DONE.
REQ-018 Latency: out_valid rises exactly NDIG cycles after the accepting edge (NDIG=1 gives 1 cycle).
REQ-019 ADD: y = (A + B) mod 2^WIDTH; c_out = carry out of bit WIDTH-1.
REQ-020 SUB: y = A + ~B + 1 mod 2^WIDTH; c_out = 1 means no borrow (A >= B unsigned).
REQ-021 NAND: y = ~(A & B); XOR: y = A ^ B; c_out = 0 for both; the carry chain is not used.
REQ-022 zero is computed from the final y and SHALL be valid whenever out_valid = 1.
REQ-023 DONE: y, c_out and zero held stable while out_valid=1 and out_ready=0; on out_ready=1 go to IDLE.
REQ-024 No bypass: a new operation is accepted no earlier than the cycle after DONE exits; peak throughput is one operation per NDIG+2 cycles.
REQ-025 a, b, op and in_valid are ignored outside IDLE; operand changes during RUN do not affect the result.
REQ-026 y, c_out and zero keep the last result in IDLE and change only during RUN/DONE processing of the next operation.

Reset
REQ-027 rst_n=0 at a clock edge: state=IDLE, idx=0, carry=0, y=0, c_out=0, zero=0, out_valid=0, in_ready=1 after the edge.
REQ-028 Reset during RUN or DONE aborts the operation; no out_valid is produced for it.
REQ-029 Reset has priority over all other inputs at the same edge.

Structure
REQ-030 Opcode constants (NAND, XOR, ADD, SUB) and FSM state encodings SHALL live in the shared params include, alongside the existing opcode defines.
REQ-031 One combinational sub-module alu_digit (DIGIT bits wide; inputs a, b, op, cin; outputs y, cout) SHALL implement one digit slice with a ripple carry; alu_serial instantiates it once.
REQ-032 An elaboration-time check SHALL reject WIDTH % DIGIT != 0.

Verification (WIDTH=8, DIGIT=4 unless stated)
REQ-033 ADD a=0x7F b=0x01 -> y=0x80, c_out=0, zero=0; out_valid exactly 2 cycles after acceptance.
REQ-034 SUB 0x05-0x05 -> y=0x00, c_out=1, zero=1; SUB 0x03-0x05 -> y=0xFE, c_out=0, zero=0.
REQ-035 NAND 0xF0,0xFF -> y=0x0F, c_out=0; XOR 0xAA,0xAA -> y=0x00, zero=1.
REQ-036 Hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changing a -> y and flags stable, in_ready=0, no second accept; the next op is accepted the cycle after out_ready=1.
REQ-037 rst_n=0 for one edge during RUN -> IDLE next cycle, out_valid never asserted for the aborted op, y=0.
REQ-038 WIDTH=8, DIGIT=8: ADD 0xFF+0x01 -> y=0x00, c_out=1, zero=1; out_valid 1 cycle after acceptance.
